// File: rtl/ristretto_dec_stage_pkg.sv
// Shared decode-stage types: control word, source-usage encodings, issue FSM states.
package ristretto_dec_stage_pkg;

    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned INFLIGHT_W = 4;

    // src_reg_used encodings; 2'b11 also means no sources.
    localparam logic [1:0] SRC_RS1     = 2'b00;
    localparam logic [1:0] SRC_RS1_RS2 = 2'b01;
    localparam logic [1:0] SRC_NONE    = 2'b10;

    typedef struct packed {
        logic [1:0] src_reg_used;
        logic       exe_reg_wr_en;
        logic       exe_csr_en;
        logic [1:0] exe_sys_priv_en;
        logic [2:0] exe_bju_en;
    } dec_control_word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SERIAL = 2'd2,
        BRWAIT = 2'd3
    } issue_state_e;

    // True when the instruction reads rs1.
    function automatic logic uses_rs1(input logic [1:0] src_reg_used);
        return (src_reg_used == SRC_RS1) || (src_reg_used == SRC_RS1_RS2);
    endfunction

    // True when the instruction reads rs2.
    function automatic logic uses_rs2(input logic [1:0] src_reg_used);
        return src_reg_used == SRC_RS1_RS2;
    endfunction

endpackage

// File: rtl/ristretto_scoreboard.sv
// Busy-bit vector for in-flight destination registers. Source read ports see a
// same-cycle retirement as already cleared (result is forwardable); the rd port
// does not, so a WAW follower waits one extra cycle.
module ristretto_scoreboard
    import ristretto_dec_stage_pkg::*;
#(
    parameter int unsigned NREGS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    input  logic [REG_IDX_W-1:0] rd_idx,
    output logic                 rs1_busy_c,
    output logic                 rs2_busy_c,
    output logic                 rd_busy_c
);

    logic [NREGS-1:0] sb_q;
    logic [NREGS-1:0] sb_d;

    // Clear first so a same-cycle set of the same index wins; x0 never busy.
    always_comb begin
        sb_d = sb_q;
        if (clr_en) begin
            sb_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            sb_d[set_idx] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // Busy-bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // Read ports.
    always_comb begin
        rs1_busy_c = sb_q[rs1_idx] & ~(clr_en & (clr_idx == rs1_idx));
        rs2_busy_c = sb_q[rs2_idx] & ~(clr_en & (clr_idx == rs2_idx));
        rd_busy_c  = sb_q[rd_idx];
    end

endmodule

// File: rtl/ristretto_issue_ctrl.sv
// Decode-to-execute issue controller: RAW/WAW interlock, in-flight limit,
// SYSTEM serialisation and branch-resolution wait.
module ristretto_issue_ctrl
    import ristretto_dec_stage_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned NREGS        = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dec_valid_i,
    input  dec_control_word_t     dec_cw_i,
    input  logic [REG_IDX_W-1:0]  dec_rs1_i,
    input  logic [REG_IDX_W-1:0]  dec_rs2_i,
    input  logic [REG_IDX_W-1:0]  dec_rd_i,
    input  logic                  exe_ready_i,
    input  logic                  retire_i,
    input  logic                  retire_wr_i,
    input  logic [REG_IDX_W-1:0]  retire_rd_i,
    input  logic                  bju_resolved_i,
    input  logic                  flush_i,
    output logic                  issue_o,
    output logic                  dec_stall_o,
    output logic [INFLIGHT_W-1:0] inflight_o
);

    issue_state_e          state_q;
    issue_state_e          state_d;
    logic [INFLIGHT_W-1:0] inflight_q;
    logic [INFLIGHT_W-1:0] inflight_d;

    logic rs1_busy_c;
    logic rs2_busy_c;
    logic rd_busy_c;
    logic hazard_c;
    logic is_sys_c;
    logic is_bju_c;
    logic writes_rd_c;
    logic below_max_c;
    logic base_ok_c;
    logic issue_c;

    ristretto_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .set_en     (issue_c & writes_rd_c),
        .set_idx    (dec_rd_i),
        .clr_en     (retire_i & retire_wr_i),
        .clr_idx    (retire_rd_i),
        .rs1_idx    (dec_rs1_i),
        .rs2_idx    (dec_rs2_i),
        .rd_idx     (dec_rd_i),
        .rs1_busy_c (rs1_busy_c),
        .rs2_busy_c (rs2_busy_c),
        .rd_busy_c  (rd_busy_c)
    );

    // Instruction classification and state-independent issue qualification.
    always_comb begin
        writes_rd_c = dec_cw_i.exe_reg_wr_en & (dec_rd_i != '0);
        hazard_c    = (uses_rs1(dec_cw_i.src_reg_used) & rs1_busy_c)
                    | (uses_rs2(dec_cw_i.src_reg_used) & rs2_busy_c)
                    | (writes_rd_c & rd_busy_c);
        is_sys_c    = dec_cw_i.exe_csr_en | (dec_cw_i.exe_sys_priv_en != '0);
        is_bju_c    = dec_cw_i.exe_bju_en != '0;
        below_max_c = inflight_q < INFLIGHT_W'(MAX_INFLIGHT);
        base_ok_c   = dec_valid_i & exe_ready_i & ~flush_i & ~hazard_c & below_max_c;
    end

    // Issue FSM next-state and issue decision.
    always_comb begin
        state_d = state_q;
        issue_c = 1'b0;
        unique case (state_q)
            RUN: begin
                if (dec_valid_i && !flush_i && is_sys_c && (inflight_q != '0)) begin
                    state_d = DRAIN;
                end else if (base_ok_c) begin
                    issue_c = 1'b1;
                    if (is_sys_c) begin
                        state_d = SERIAL;
                    end else if (is_bju_c) begin
                        state_d = BRWAIT;
                    end
                end
            end
            DRAIN: begin
                if (flush_i || (inflight_q == '0)) begin
                    state_d = RUN;
                end
            end
            SERIAL: begin
                if (retire_i && (inflight_q == INFLIGHT_W'(1))) begin
                    state_d = RUN;
                end
            end
            BRWAIT: begin
                if (bju_resolved_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // In-flight counter update, saturating at both ends.
    always_comb begin
        inflight_d = inflight_q;
        if (issue_c && !retire_i) begin
            if (inflight_q != '1) begin
                inflight_d = inflight_q + INFLIGHT_W'(1);
            end
        end else if (!issue_c && retire_i) begin
            if (inflight_q != '0) begin
                inflight_d = inflight_q - INFLIGHT_W'(1);
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    // Output drive.
    always_comb begin
        issue_o     = issue_c;
        dec_stall_o = dec_valid_i & ~issue_c & ~flush_i;
        inflight_o  = inflight_q;
    end

    // Protocol checks: never retire with nothing outstanding, never issue past the limit.
    retire_when_empty_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(retire_i && (inflight_q == '0)));
    issue_when_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(issue_c && !below_max_c));

endmodule
